// File: rtl/par_clk_switch_ctrl_if.sv
// Control bundle between system configuration / downstream logic, the
// parallel-clock mux, and the par_clk switch sequencer.
interface par_clk_switch_ctrl_if;
  logic       cfg_valid;
  logic [1:0] cfg_mode;
  logic       cfg_ready;
  logic       quiesce_req;
  logic       quiesce_ack;
  logic       mux_clk_sel;
  logic       mux_clk_pdwn;
  logic       mux_reset_n;
  logic       par_clk_rdy;
  logic       link_up;
  logic       fault;
  logic [1:0] fault_code;
  logic       fault_clr;
  logic [2:0] ctrl_state;

  // System / mux / downstream side
  modport master (
    output cfg_valid, cfg_mode, quiesce_ack, par_clk_rdy, fault_clr,
    input  cfg_ready, quiesce_req, mux_clk_sel, mux_clk_pdwn, mux_reset_n,
           link_up, fault, fault_code, ctrl_state
  );

  // Sequencer side
  modport slave (
    input  cfg_valid, cfg_mode, quiesce_ack, par_clk_rdy, fault_clr,
    output cfg_ready, quiesce_req, mux_clk_sel, mux_clk_pdwn, mux_reset_n,
           link_up, fault, fault_code, ctrl_state
  );
endinterface

// File: rtl/par_clk_switch_ctrl.sv
// Sequencer for parallel-clock mode changes: quiesce downstream, reprogram
// the mux, pulse its reset and wait for ready, with timeouts into FAULT.
module par_clk_switch_ctrl #(
  parameter int unsigned HOLD_CYC     = 16,
  parameter int unsigned QACK_TIMEOUT = 256,
  parameter int unsigned RDY_TIMEOUT  = 4096,
  parameter int unsigned CNT_W        = 13
) (
  input  logic                 par_clk,
  input  logic                 clk_reset_n,
  par_clk_switch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    MUX_RST  = 3'd0,
    WAIT_RDY = 3'd1,
    RUN      = 3'd2,
    QUIESCE  = 3'd3,
    FAULT    = 3'd4
  } state_t;

  // Counter value on the last cycle of each timed state
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] QACK_LAST = CNT_W'(QACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RDY_LAST  = CNT_W'(RDY_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cur_mode;
  logic [1:0]       new_mode;
  logic [1:0]       req_mode;

  // Mode to {mux_clk_sel, mux_clk_pdwn}; reserved mode behaves as both dies
  function automatic logic [1:0] mode_map(input logic [1:0] m);
    case (m)
      2'b01:   mode_map = 2'b01;
      2'b10:   mode_map = 2'b11;
      default: mode_map = 2'b00;
    endcase
  endfunction

  // Reserved request mode folds to both dies at acceptance
  assign req_mode = (bus.cfg_mode == 2'b11) ? 2'b00 : bus.cfg_mode;

  assign bus.ctrl_state = state;

  // Sequencer state, counter and registered outputs
  always_ff @(posedge par_clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      state            <= MUX_RST;
      cnt              <= '0;
      cur_mode         <= 2'b00;
      new_mode         <= 2'b00;
      bus.mux_reset_n  <= 1'b0;
      bus.mux_clk_sel  <= 1'b0;
      bus.mux_clk_pdwn <= 1'b0;
      bus.quiesce_req  <= 1'b0;
      bus.link_up      <= 1'b0;
      bus.fault        <= 1'b0;
      bus.fault_code   <= 2'b00;
      bus.cfg_ready    <= 1'b0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      case (state)
        MUX_RST: begin
          if (cnt == HOLD_LAST) begin
            bus.mux_reset_n <= 1'b1;
            state           <= WAIT_RDY;
            cnt             <= '0;
          end
        end
        WAIT_RDY: begin
          if (bus.par_clk_rdy) begin
            bus.link_up     <= 1'b1;
            bus.quiesce_req <= 1'b0;
            bus.cfg_ready   <= 1'b1;
            state           <= RUN;
            cnt             <= '0;
          end else if (cnt == RDY_LAST) begin
            bus.fault       <= 1'b1;
            bus.fault_code  <= 2'b10;
            bus.quiesce_req <= 1'b0;
            state           <= FAULT;
            cnt             <= '0;
          end
        end
        RUN: begin
          bus.cfg_ready <= bus.par_clk_rdy;
          if (!bus.par_clk_rdy) begin
            bus.fault      <= 1'b1;
            bus.fault_code <= 2'b11;
            bus.link_up    <= 1'b0;
            bus.cfg_ready  <= 1'b0;
            state          <= FAULT;
            cnt            <= '0;
          end else if (bus.cfg_valid && bus.cfg_ready && (req_mode != cur_mode)) begin
            new_mode        <= req_mode;
            bus.quiesce_req <= 1'b1;
            bus.link_up     <= 1'b0;
            bus.cfg_ready   <= 1'b0;
            state           <= QUIESCE;
            cnt             <= '0;
          end
        end
        QUIESCE: begin
          if (bus.quiesce_ack) begin
            cur_mode                           <= new_mode;
            {bus.mux_clk_sel, bus.mux_clk_pdwn} <= mode_map(new_mode);
            bus.mux_reset_n                    <= 1'b0;
            state                              <= MUX_RST;
            cnt                                <= '0;
          end else if (cnt == QACK_LAST) begin
            bus.fault       <= 1'b1;
            bus.fault_code  <= 2'b01;
            bus.quiesce_req <= 1'b0;
            state           <= FAULT;
            cnt             <= '0;
          end
        end
        FAULT: begin
          if (bus.fault_clr) begin
            bus.fault                          <= 1'b0;
            bus.fault_code                     <= 2'b00;
            {bus.mux_clk_sel, bus.mux_clk_pdwn} <= mode_map(cur_mode);
            bus.mux_reset_n                    <= 1'b0;
            state                              <= MUX_RST;
            cnt                                <= '0;
          end
        end
        default: begin
          bus.mux_reset_n <= 1'b0;
          state           <= MUX_RST;
          cnt             <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_clk_switch_ctrl.sv
// Directed + randomized bench for par_clk_switch_ctrl with a mode/timing
// reference model kept at the level of the behavioural rules.
module tb_par_clk_switch_ctrl;

  localparam int HOLD = 16;
  localparam int QACK = 256;
  localparam int RDYT = 4096;

  localparam logic [2:0] S_MUX_RST  = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_QUIESCE  = 3'd3;
  localparam logic [2:0] S_FAULT    = 3'd4;

  logic par_clk;
  logic clk_reset_n;
  int   checks;
  int   errors;
  logic [1:0] cur_m;

  par_clk_switch_ctrl_if bus();

  par_clk_switch_ctrl #(
    .HOLD_CYC(HOLD), .QACK_TIMEOUT(QACK), .RDY_TIMEOUT(RDYT), .CNT_W(13)
  ) dut (
    .par_clk(par_clk),
    .clk_reset_n(clk_reset_n),
    .bus(bus)
  );

  initial par_clk = 1'b0;
  always #5 par_clk = ~par_clk;

  // Expected {sel, pdwn} for a mode, from the mode table
  function automatic logic [1:0] exp_mux(input logic [1:0] m);
    logic [1:0] tbl [4];
    tbl = '{2'b00, 2'b01, 2'b11, 2'b00};
    return tbl[m];
  endfunction

  function automatic logic [1:0] fold(input logic [1:0] m);
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge par_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(bus.ctrl_state), 32'(S_MUX_RST));
    check({tag, "_mrst"},  32'(bus.mux_reset_n), 0);
    check({tag, "_sel"},   32'(bus.mux_clk_sel), 0);
    check({tag, "_pdwn"},  32'(bus.mux_clk_pdwn), 0);
    check({tag, "_qreq"},  32'(bus.quiesce_req), 0);
    check({tag, "_link"},  32'(bus.link_up), 0);
    check({tag, "_fault"}, 32'(bus.fault), 0);
    check({tag, "_code"},  32'(bus.fault_code), 0);
    check({tag, "_rdy"},   32'(bus.cfg_ready), 0);
  endtask

  // Count observed cycles until mux_reset_n is released
  task automatic measure_low(output int n);
    n = 0;
    while (bus.mux_reset_n !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, output int n);
    n = 0;
    while (bus.ctrl_state !== s && n < lim) begin
      cyc();
      n++;
    end
  endtask

  // From MUX_RST: check hold length, raise ready after d cycles, expect RUN
  task automatic bring_up(input string tag, input int d, input logic qexp);
    int n;
    measure_low(n);
    check({tag, "_hold"}, n, HOLD);
    check({tag, "_qreq_wait"}, 32'(bus.quiesce_req), 32'(qexp));
    cyc(d);
    check({tag, "_still_wait"}, 32'(bus.ctrl_state), 32'(S_WAIT_RDY));
    check({tag, "_link_pre"}, 32'(bus.link_up), 0);
    bus.par_clk_rdy = 1'b1;
    cyc();
    check({tag, "_run"}, 32'(bus.ctrl_state), 32'(S_RUN));
    check({tag, "_link"}, 32'(bus.link_up), 1);
    check({tag, "_qreq_run"}, 32'(bus.quiesce_req), 0);
    check({tag, "_cfg_rdy"}, 32'(bus.cfg_ready), 1);
    check({tag, "_mux"}, 32'({bus.mux_clk_sel, bus.mux_clk_pdwn}), 32'(exp_mux(cur_m)));
  endtask

  // Issue a request from RUN; if the mode changes, ack after ack_d cycles
  task automatic request_and_ack(input string tag, input logic [1:0] raw, input int ack_d,
                                 output bit switched);
    logic [1:0] m;
    m = fold(raw);
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = raw;
    cyc();
    bus.cfg_valid = 1'b0;
    switched = (m != cur_m);
    if (!switched) begin
      check({tag, "_same_state"}, 32'(bus.ctrl_state), 32'(S_RUN));
      check({tag, "_same_qreq"}, 32'(bus.quiesce_req), 0);
      check({tag, "_same_mrst"}, 32'(bus.mux_reset_n), 1);
      check({tag, "_same_mux"}, 32'({bus.mux_clk_sel, bus.mux_clk_pdwn}), 32'(exp_mux(cur_m)));
    end else begin
      check({tag, "_q_state"}, 32'(bus.ctrl_state), 32'(S_QUIESCE));
      check({tag, "_q_req"}, 32'(bus.quiesce_req), 1);
      check({tag, "_q_link"}, 32'(bus.link_up), 0);
      check({tag, "_q_cfgrdy"}, 32'(bus.cfg_ready), 0);
      cyc(ack_d);
      check({tag, "_mux_old"}, 32'({bus.mux_clk_sel, bus.mux_clk_pdwn}), 32'(exp_mux(cur_m)));
      bus.quiesce_ack = 1'b1;
      cyc();
      bus.quiesce_ack = 1'b0;
      bus.par_clk_rdy = 1'b0;
      cur_m = m;
      check({tag, "_ack_state"}, 32'(bus.ctrl_state), 32'(S_MUX_RST));
      check({tag, "_ack_mrst"}, 32'(bus.mux_reset_n), 0);
      check({tag, "_mux_new"}, 32'({bus.mux_clk_sel, bus.mux_clk_pdwn}), 32'(exp_mux(cur_m)));
      check({tag, "_ack_qreq"}, 32'(bus.quiesce_req), 1);
    end
  endtask

  task automatic clear_fault(input string tag);
    bus.fault_clr = 1'b1;
    cyc();
    bus.fault_clr = 1'b0;
    bus.par_clk_rdy = 1'b0;
    check({tag, "_clr_state"}, 32'(bus.ctrl_state), 32'(S_MUX_RST));
    check({tag, "_clr_fault"}, 32'(bus.fault), 0);
    check({tag, "_clr_code"}, 32'(bus.fault_code), 0);
    check({tag, "_clr_mrst"}, 32'(bus.mux_reset_n), 0);
  endtask

  initial begin
    int  n;
    bit  sw;
    logic [1:0] raw;
    logic [1:0] tgt;
    checks = 0;
    errors = 0;
    cur_m  = 2'b00;
    clk_reset_n     = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_mode    = 2'b00;
    bus.quiesce_ack = 1'b0;
    bus.par_clk_rdy = 1'b0;
    bus.fault_clr   = 1'b0;

    // Reset values, then first bring-up with ready 1100 cycles after release
    cyc(3);
    check_reset_vals("reset");
    clk_reset_n = 1'b1;
    bring_up("init", 1100, 1'b0);

    // Same-mode and reserved-mode requests are consumed without a switch
    request_and_ack("same00", 2'b00, 0, sw);
    request_and_ack("resv11", 2'b11, 0, sw);
    bus.fault_clr = 1'b1;
    cyc();
    bus.fault_clr = 1'b0;
    check("clr_in_run_state", 32'(bus.ctrl_state), 32'(S_RUN));
    check("clr_in_run_fault", 32'(bus.fault), 0);

    // Switch to die 2 only, ack five cycles after quiesce_req
    request_and_ack("sw10", 2'b10, 4, sw);
    bring_up("sw10_up", 1100, 1'b1);

    // Quiesce timeout
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'b01;
    cyc();
    bus.cfg_valid = 1'b0;
    check("qto_enter", 32'(bus.ctrl_state), 32'(S_QUIESCE));
    wait_state(S_FAULT, 400, n);
    check("qto_cycles", n, QACK);
    check("qto_code", 32'(bus.fault_code), 32'h1);
    check("qto_fault", 32'(bus.fault), 1);
    check("qto_mux", 32'({bus.mux_clk_sel, bus.mux_clk_pdwn}), 32'(exp_mux(cur_m)));
    check("qto_cfgrdy", 32'(bus.cfg_ready), 0);
    check("qto_qreq", 32'(bus.quiesce_req), 0);
    check("qto_link", 32'(bus.link_up), 0);
    clear_fault("qto");
    bring_up("qto_up", $urandom_range(1030, 1200), 1'b0);

    // Randomized mode changes against the model
    for (int i = 0; i < 6; i++) begin
      raw = 2'($urandom_range(0, 3));
      request_and_ack($sformatf("rnd%0d", i), raw, $urandom_range(0, 30), sw);
      if (sw) bring_up($sformatf("rnd%0d_up", i), $urandom_range(1030, 1200), 1'b1);
    end

    // Ready never rises: timeout into FAULT code 10
    tgt = (cur_m == 2'b10) ? 2'b01 : 2'b10;
    request_and_ack("rto", tgt, 2, sw);
    measure_low(n);
    check("rto_hold", n, HOLD);
    wait_state(S_FAULT, 5000, n);
    check("rto_cycles", n, RDYT);
    check("rto_code", 32'(bus.fault_code), 32'h2);
    check("rto_fault", 32'(bus.fault), 1);
    check("rto_mux", 32'({bus.mux_clk_sel, bus.mux_clk_pdwn}), 32'(exp_mux(cur_m)));
    clear_fault("rto");
    // Ready arrives exactly on the timeout cycle
    bring_up("rto_edge", RDYT - 1, 1'b0);
    check("rto_edge_fault", 32'(bus.fault), 0);

    // Ready lost while a request is offered
    bus.par_clk_rdy = 1'b0;
    bus.cfg_valid   = 1'b1;
    bus.cfg_mode    = (cur_m == 2'b10) ? 2'b00 : 2'b10;
    cyc();
    bus.cfg_valid = 1'b0;
    check("lost_state", 32'(bus.ctrl_state), 32'(S_FAULT));
    check("lost_code", 32'(bus.fault_code), 32'h3);
    check("lost_qreq", 32'(bus.quiesce_req), 0);
    check("lost_cfgrdy", 32'(bus.cfg_ready), 0);
    check("lost_mux", 32'({bus.mux_clk_sel, bus.mux_clk_pdwn}), 32'(exp_mux(cur_m)));
    clear_fault("lost");
    measure_low(n);
    check("lost_hold", n, HOLD);
    cyc(3);
    check("mid_wait_state", 32'(bus.ctrl_state), 32'(S_WAIT_RDY));
    check("mid_wait_mux", 32'({bus.mux_clk_sel, bus.mux_clk_pdwn}), 32'(exp_mux(cur_m)));

    // Asynchronous reset mid-WAIT_RDY, checked before the next clock edge
    #2;
    clk_reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    cyc(2);
    clk_reset_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
